genius_key_capture: RTL and testbench
=====================================

Name: genius_key_capture

Overview:
- User-side input path of the Genius game, the counterpart to the LED/HEX sequence playback.
- Conditions the four raw push-buttons (synchronize, debounce, press-detect) and encodes each press as a 2-bit colour code.
- Stores the codes in order in a small sequence buffer and tells the controller when the user has entered a full round.
- The datapath reads the stored codes back by index and compares them against the FPGA sequence.

Parameters:
- N_KEY, 4, number of push-buttons; fixed at 4 for 2-bit codes.
- DEB_CYCLES, 1000000, stable-sample count needed to accept a level change (20 ms at 50 MHz).
- MAX_LEN, 32, sequence buffer depth in entries.
- TIMEOUT_CYCLES, 250000000, inactivity limit (5 s); used only with the optional feature.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low; clears all state.
- KEY  in  4  raw buttons, active-low (pressed = 0), asynchronous to CLOCK_50.
- enable  in  1  high while the controller is in its user-entry state.
- round_len  in  6  number of entries expected this round.
- rd_idx  in  5  buffer read index.
- rd_code  out  2  buffer[rd_idx], registered, 1-cycle latency.
- key_valid  out  1  one-cycle pulse per accepted press.
- key_code  out  2  code of the latest accepted press; held until the next press.
- count  out  6  entries captured this round.
- end_User  out  1  full round captured; level signal.
- end_time  out  1  inactivity timeout; level signal.
- leds  out  4  live debounced key state, active-high, for echo to LEDR.

Behaviour:
- Reset: all outputs 0, count 0, FSM in IDLE, debounced state "released" (all 1s). Buffer contents need not be cleared.
- Input conditioning, per key:
  - 2-FF synchronizer, then a debounce counter.
  - Counter resets whenever the synced value equals the stable value.
  - Stable value flips when the counter reaches DEB_CYCLES-1.
  - Press event = stable transition 1->0. Release produces no event.
- Latency: press event to key_valid is exactly 1 cycle. Raw edge to key_valid is 2 + DEB_CYCLES + 1 cycles.
- Simultaneous press events in the same cycle: lowest key index wins; the others are discarded, not queued.
- Code encoding: KEY[0]=0, KEY[1]=1, KEY[2]=2, KEY[3]=3.
- Effective length: L = round_len clamped to 1..MAX_LEN. 0 is treated as 1; values above MAX_LEN are treated as MAX_LEN. L is sampled on IDLE->CAPTURE entry.
- FSM state IDLE:
  - count=0, end_User=0, end_time=0.
  - Moves to CAPTURE when enable=1.
- FSM state CAPTURE, on a press event:
  - write buffer[count], update key_code, pulse key_valid, count++.
  - If count+1==L, go to DONE; end_User=1 from the same edge as the final key_valid.
- FSM state DONE:
  - end_User held; further presses ignored (no key_valid).
  - Moves to IDLE when enable=0.
- enable falling in CAPTURE: go to IDLE and clear count. A press event in that same cycle is dropped.
- Presses outside CAPTURE produce no key_valid and no buffer write. leds always follows the debounced state.
- rd_idx >= count returns stale data; the caller must not use it. Read and write to the same index in one cycle returns the old value.
- Reset mid-press: the key must be released, then pressed again, before it produces an event.

Optional Feature:
- Macro: GENIUS_KEY_TIMEOUT_EN.
- Enabled:
  - Inactivity counter runs in CAPTURE and restarts on entry and on every accepted press.
  - On reaching TIMEOUT_CYCLES-1: go to DONE with end_time=1 and end_User=0.
  - end_time is held until IDLE.
- Disabled: no counter is built and end_time is tied to 0.

Decomposition:
- Package genius_pkg holds:
  - key code constants: GREEN=0, RED=1, YELLOW=2, BLUE=3;
  - the capture FSM state encoding: IDLE, CAPTURE, DONE;
  - the default DEB_CYCLES, MAX_LEN and TIMEOUT_CYCLES.
- Sub-module key_debounce: synchronizer, debounce counter and press pulse for one key, instantiated N_KEY times.

Test Plan (DEB_CYCLES=4, TIMEOUT_CYCLES=64 in sim):
- Raw KEY[2] bounces 0/1/0 in 1-cycle toggles, then is held 0 -> exactly one key_valid, key_code=2, leds[2]=1; no event on release.
- enable=1, round_len=3, presses 1,3,0 -> key_valid x3, count goes 1,2,3, end_User=1 with the 3rd pulse; rd_idx 0..2 returns 1,3,0 one cycle later.
- KEY[1] and KEY[3] reach their press events in the same cycle -> one key_valid, code 1, count +1.
- round_len=0 -> one press reaches DONE. round_len=40 -> DONE at count=32.
- enable dropped after 2 of 4 presses -> IDLE, count=0; presses ignored while enable=0; a fresh round starts at buffer index 0.
- With GENIUS_KEY_TIMEOUT_EN: no press for 64 cycles in CAPTURE -> end_time=1, end_User=0. Without the macro: end_time stays 0.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius key-capture path.
// Holds the colour codes produced for each button, the capture FSM state encoding,
// default timing/size parameters and the round-length clamp helper.
package genius_pkg;

  // Colour code per push-button index
  localparam logic [1:0] GREEN  = 2'd0;
  localparam logic [1:0] RED    = 2'd1;
  localparam logic [1:0] YELLOW = 2'd2;
  localparam logic [1:0] BLUE   = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDone
  } cap_state_e;

  localparam int unsigned DefDebCycles     = 1000000;    // 20 ms at 50 MHz
  localparam int unsigned DefMaxLen        = 32;
  localparam int unsigned DefTimeoutCycles = 250000000;  // 5 s at 50 MHz

  // Effective round length: 0 behaves as 1, anything above the buffer depth saturates.
  function automatic logic [5:0] clamp_len(input logic [5:0] len, input logic [5:0] max_len);
    if (len == 6'd0) return 6'd1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/genius_key_capture_if.sv
// Controller <-> key-capture bus of the Genius game.
//   enable     controller is in its user-entry state
//   round_len  entries expected this round
//   rd_idx     buffer read index; rd_code returns buffer[rd_idx] one cycle later
//   key_valid  one-cycle pulse per accepted press, key_code holds its colour
//   count      entries captured this round
//   end_User   full round captured (level); end_time inactivity timeout (level)
// master: controller side; slave: key-capture side.
interface genius_key_capture_if;
  logic       enable;
  logic [5:0] round_len;
  logic [4:0] rd_idx;
  logic [1:0] rd_code;
  logic       key_valid;
  logic [1:0] key_code;
  logic [5:0] count;
  logic       end_User;
  logic       end_time;

  modport master (
    output enable, round_len, rd_idx,
    input  rd_code, key_valid, key_code, count, end_User, end_time
  );

  modport slave (
    input  enable, round_len, rd_idx,
    output rd_code, key_valid, key_code, count, end_User, end_time
  );
endinterface

// File: rtl/key_debounce.sv
// Conditioning for one active-low push-button.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   key_ni         raw button, active-low, asynchronous to clk_i
//   stable_o       debounced level (1 = released)
//   press_o        one-cycle pulse, registered, on a debounced 1->0 transition
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic stable_o,
  output logic press_o
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]      sync_q;
  logic            synced;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;
  logic            armed_q, armed_d;
  logic            press_q, press_d;

  assign synced = sync_q[1];

  // armed_q only sets once the key has been seen released after reset, so a button
  // held through reset settles to "pressed" without producing an event.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    armed_d  = armed_q;
    press_d  = 1'b0;
    if (synced == stable_q) begin
      cnt_d = '0;
      if (synced) armed_d = 1'b1;
    end else if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
      cnt_d    = '0;
      stable_d = synced;
      press_d  = stable_q & armed_q;  // flipping away from 1 means a press
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer resets to "pressed" so the release check above needs a real sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b1;
      armed_q  <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_ni};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      armed_q  <= armed_d;
      press_q  <= press_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/genius_key_capture.sv
// User-side input path of the Genius game: debounces the four buttons, encodes each
// accepted press as a colour code, stores the codes in order and flags a full round.
//   CLOCK_50  system clock
//   reset     asynchronous active-low reset
//   KEY       raw buttons, active-low
//   leds      live debounced key state, active-high
//   bus       controller bus (slave side), see genius_key_capture_if
// Optional inactivity timeout: define GENIUS_KEY_TIMEOUT_EN (adds TIMEOUT_CYCLES).
module genius_key_capture
  import genius_pkg::*;
#(
  parameter int unsigned N_KEY      = 4,
  parameter int unsigned DEB_CYCLES = DefDebCycles,
  parameter int unsigned MAX_LEN    = DefMaxLen
`ifdef GENIUS_KEY_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
`endif
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [N_KEY-1:0] KEY,
  output logic [N_KEY-1:0] leds,
  genius_key_capture_if.slave bus
);

  localparam int unsigned AddrW = $clog2(MAX_LEN);

  logic [N_KEY-1:0] stable, press;
  logic             press_any;
  logic [1:0]       press_code;

  cap_state_e state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [5:0] len_q, len_d;
  logic [1:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic [1:0] rd_code_q;
  logic       wr_en;
  logic       tmo_hit;
  logic       end_time_s;
  logic [1:0] mem_q [MAX_LEN];

  for (genvar g = 0; g < N_KEY; g++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_key_debounce (
      .clk_i   (CLOCK_50),
      .rst_ni  (reset),
      .key_ni  (KEY[g]),
      .stable_o(stable[g]),
      .press_o (press[g])
    );
  end

  assign leds = ~stable;

  // Lowest index wins; simultaneous higher-index presses are discarded.
  always_comb begin
    press_any  = 1'b0;
    press_code = GREEN;
    for (int i = N_KEY - 1; i >= 0; i--) begin
      if (press[i]) begin
        press_any  = 1'b1;
        press_code = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      StIdle: begin
        count_d = '0;
        if (bus.enable) begin
          state_d = StCapture;
          len_d   = clamp_len(bus.round_len, 6'(MAX_LEN));
        end
      end
      StCapture: begin
        if (!bus.enable) begin
          // A press landing in this cycle is dropped with the round.
          state_d = StIdle;
          count_d = '0;
        end else if (press_any) begin
          wr_en       = 1'b1;
          key_code_d  = press_code;
          key_valid_d = 1'b1;
          count_d     = count_q + 6'd1;
          if (count_q + 6'd1 == len_q) state_d = StDone;
        end else if (tmo_hit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!bus.enable) begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      len_q       <= 6'd1;
      key_code_q  <= GREEN;
      key_valid_q <= 1'b0;
      rd_code_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      rd_code_q   <= mem_q[bus.rd_idx];  // old data on same-cycle read/write
    end
  end

  // Buffer contents survive reset; only entries below count are meaningful.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem_q[count_q[AddrW-1:0]] <= press_code;
  end

`ifdef GENIUS_KEY_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            end_time_q;

  // Restarts on CAPTURE entry (counter is 0 outside CAPTURE) and on each press.
  always_comb begin
    tmo_d = '0;
    if (state_q == StCapture && !press_any) tmo_d = tmo_q + 1'b1;
  end

  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // CAPTURE->DONE without a press can only be the timeout.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      tmo_q      <= '0;
      end_time_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      end_time_q <= (state_d == StDone) &&
                    (end_time_q || (state_q == StCapture && !press_any));
    end
  end

  assign end_time_s = end_time_q;
`else
  assign tmo_hit    = 1'b0;
  assign end_time_s = 1'b0;
`endif

  assign bus.rd_code   = rd_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.count     = count_q;
  assign bus.end_User  = (state_q == StDone) && !end_time_s;
  assign bus.end_time  = end_time_s;

endmodule

// File: tb/tb_genius_key_capture.sv
// Directed bench for genius_key_capture with short debounce and timeout settings.
module tb_genius_key_capture;
  import genius_pkg::*;

  localparam int unsigned DebCycles = 4;
  localparam int unsigned MaxLen    = 32;
`ifdef GENIUS_KEY_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 64;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] leds;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_pulse  = 0;
  int unsigned p0;
  logic        eu_at_pulse = 1'b0;
  logic [5:0]  cnt_at_pulse = '0;

  genius_key_capture_if bus ();

  genius_key_capture #(
    .N_KEY     (4),
    .DEB_CYCLES(DebCycles),
    .MAX_LEN   (MaxLen)
`ifdef GENIUS_KEY_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TimeoutCycles)
`endif
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst_n),
    .KEY     (key),
    .leds    (leds),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      n_pulse      = n_pulse + 1;
      eu_at_pulse  = bus.end_User;
      cnt_at_pulse = bus.count;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // All stimulus is applied 1 time unit after a rising edge.
  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_release(input int unsigned idx);
    key[idx] = 1'b0;
    step(12);
    key[idx] = 1'b1;
    step(12);
  endtask

  task automatic read_chk(input string tag, input logic [4:0] idx, input logic [1:0] exp);
    bus.rd_idx = idx;
    step(1);
    check_eq(tag, 32'(bus.rd_code), 32'(exp));
  endtask

  initial begin
    rst_n         = 1'b0;
    key           = 4'hF;
    bus.enable    = 1'b0;
    bus.round_len = 6'd0;
    bus.rd_idx    = 5'd0;
    step(3);
    check_eq("rst_key_valid", 32'(bus.key_valid), 32'd0);
    check_eq("rst_count", 32'(bus.count), 32'd0);
    check_eq("rst_end_user", 32'(bus.end_User), 32'd0);
    check_eq("rst_end_time", 32'(bus.end_time), 32'd0);
    check_eq("rst_leds", 32'(leds), 32'd0);
    check_eq("rst_key_code", 32'(bus.key_code), 32'd0);
    check_eq("rst_rd_code", 32'(bus.rd_code), 32'd0);
    rst_n = 1'b1;
    step(5);

    // Bouncing KEY[2]
    bus.enable    = 1'b1;
    bus.round_len = 6'd5;
    step(2);
    p0 = n_pulse;
    key[2] = 1'b0; step(1);
    key[2] = 1'b1; step(1);
    key[2] = 1'b0; step(12);
    check_eq("bounce_pulses", n_pulse - p0, 32'd1);
    check_eq("bounce_code", 32'(bus.key_code), 32'(YELLOW));
    check_eq("bounce_leds", 32'(leds), 32'h4);
    check_eq("bounce_count", 32'(bus.count), 32'd1);
    key[2] = 1'b1;
    step(12);
    check_eq("release_pulses", n_pulse - p0, 32'd1);
    check_eq("release_leds", 32'(leds), 32'h0);
    bus.enable = 1'b0;
    step(2);
    check_eq("abort_count", 32'(bus.count), 32'd0);

    // Round of 3: codes 1,3,0, exact press latency on the first
    bus.round_len = 6'd3;
    bus.enable    = 1'b1;
    step(2);
    key[1] = 1'b0;
    step(6);
    check_eq("lat_pre", 32'(bus.key_valid), 32'd0);
    step(1);
    check_eq("lat_pulse", 32'(bus.key_valid), 32'd1);
    check_eq("lat_code", 32'(bus.key_code), 32'(RED));
    check_eq("lat_count", 32'(bus.count), 32'd1);
    step(1);
    check_eq("lat_after", 32'(bus.key_valid), 32'd0);
    key[1] = 1'b1;
    step(12);
    press_release(3);
    check_eq("r3_count2", 32'(bus.count), 32'd2);
    check_eq("r3_eu_early", 32'(bus.end_User), 32'd0);
    p0 = n_pulse;
    press_release(0);
    check_eq("r3_last_pulse", n_pulse - p0, 32'd1);
    check_eq("r3_eu_with_pulse", 32'(eu_at_pulse), 32'd1);
    check_eq("r3_cnt_with_pulse", 32'(cnt_at_pulse), 32'd3);
    check_eq("r3_code", 32'(bus.key_code), 32'(GREEN));
    read_chk("r3_rd0", 5'd0, 2'd1);
    read_chk("r3_rd1", 5'd1, 2'd3);
    read_chk("r3_rd2", 5'd2, 2'd0);
    p0 = n_pulse;
    press_release(2);
    check_eq("done_no_pulse", n_pulse - p0, 32'd0);
    check_eq("done_eu_held", 32'(bus.end_User), 32'd1);
    check_eq("done_count", 32'(bus.count), 32'd3);
    check_eq("done_code_held", 32'(bus.key_code), 32'(GREEN));
    bus.enable = 1'b0;
    step(2);
    check_eq("idle_eu", 32'(bus.end_User), 32'd0);
    check_eq("idle_count", 32'(bus.count), 32'd0);

    // KEY[1] and KEY[3] together: lowest index wins
    bus.round_len = 6'd4;
    bus.enable    = 1'b1;
    step(2);
    p0 = n_pulse;
    key[1] = 1'b0;
    key[3] = 1'b0;
    step(12);
    check_eq("simul_pulses", n_pulse - p0, 32'd1);
    check_eq("simul_code", 32'(bus.key_code), 32'(RED));
    check_eq("simul_count", 32'(bus.count), 32'd1);
    key = 4'hF;
    step(12);
    bus.enable = 1'b0;
    step(2);

    // round_len 0 behaves as 1
    bus.round_len = 6'd0;
    bus.enable    = 1'b1;
    step(2);
    press_release(2);
    check_eq("len0_eu", 32'(bus.end_User), 32'd1);
    check_eq("len0_count", 32'(bus.count), 32'd1);
    bus.enable = 1'b0;
    step(2);

    // round_len 40 saturates at 32
    bus.round_len = 6'd40;
    bus.enable    = 1'b1;
    step(2);
    for (int i = 0; i < 31; i++) press_release(i % 4);
    check_eq("len40_count31", 32'(bus.count), 32'd31);
    check_eq("len40_eu31", 32'(bus.end_User), 32'd0);
    press_release(3);
    check_eq("len40_count32", 32'(bus.count), 32'd32);
    check_eq("len40_eu32", 32'(bus.end_User), 32'd1);
    read_chk("len40_rd31", 5'd31, 2'd3);
    read_chk("len40_rd5", 5'd5, 2'd1);
    bus.enable = 1'b0;
    step(2);

    // Abort after 2 of 4, presses ignored in IDLE, fresh round starts at index 0
    bus.round_len = 6'd4;
    bus.enable    = 1'b1;
    step(2);
    press_release(3);
    press_release(2);
    check_eq("abort2_count", 32'(bus.count), 32'd2);
    bus.enable = 1'b0;
    step(2);
    check_eq("abort2_idle_count", 32'(bus.count), 32'd0);
    check_eq("abort2_idle_eu", 32'(bus.end_User), 32'd0);
    p0 = n_pulse;
    press_release(1);
    check_eq("idle_press_pulses", n_pulse - p0, 32'd0);
    check_eq("idle_press_count", 32'(bus.count), 32'd0);
    bus.enable = 1'b1;
    step(2);
    press_release(0);
    check_eq("fresh_count", 32'(bus.count), 32'd1);
    read_chk("fresh_rd0", 5'd0, 2'd0);
    bus.enable = 1'b0;
    step(2);

    // Inactivity
`ifdef GENIUS_KEY_TIMEOUT_EN
    bus.round_len = 6'd4;
    bus.enable    = 1'b1;
    step(64);
    check_eq("tmo_pre", 32'(bus.end_time), 32'd0);
    step(1);
    check_eq("tmo_hit", 32'(bus.end_time), 32'd1);
    check_eq("tmo_eu", 32'(bus.end_User), 32'd0);
    step(5);
    check_eq("tmo_held", 32'(bus.end_time), 32'd1);
    bus.enable = 1'b0;
    step(1);
    check_eq("tmo_clear", 32'(bus.end_time), 32'd0);
`else
    bus.round_len = 6'd4;
    bus.enable    = 1'b1;
    step(100);
    check_eq("no_tmo_end_time", 32'(bus.end_time), 32'd0);
    check_eq("no_tmo_eu", 32'(bus.end_User), 32'd0);
    bus.enable = 1'b0;
`endif
    step(2);

    // Reset while KEY[0] is held
    key[0] = 1'b0;
    step(10);
    rst_n = 1'b0;
    step(2);
    check_eq("midrst_leds", 32'(leds), 32'h0);
    rst_n         = 1'b1;
    bus.enable    = 1'b1;
    bus.round_len = 6'd4;
    p0 = n_pulse;
    step(15);
    check_eq("midrst_pulses", n_pulse - p0, 32'd0);
    check_eq("midrst_leds_held", 32'(leds), 32'h1);
    check_eq("midrst_count", 32'(bus.count), 32'd0);
    key[0] = 1'b1;
    step(12);
    press_release(0);
    check_eq("repress_pulses", n_pulse - p0, 32'd1);
    check_eq("repress_count", 32'(bus.count), 32'd1);
    bus.enable = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
